// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART TX feeder constants: one-hot state indices and FIFO default
package uart_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 16;

  // Bit positions inside the one-hot feeder state vector
  localparam int S_IDLE      = 0;
  localparam int S_START     = 1;
  localparam int S_WAIT_BUSY = 2;
  localparam int S_WAIT_DONE = 3;
  localparam int NUM_STATES  = 4;

  typedef logic [NUM_STATES-1:0] state_vec_t;

  localparam state_vec_t ST_IDLE      = state_vec_t'(1 << S_IDLE);
  localparam state_vec_t ST_START     = state_vec_t'(1 << S_START);
  localparam state_vec_t ST_WAIT_BUSY = state_vec_t'(1 << S_WAIT_BUSY);
  localparam state_vec_t ST_WAIT_DONE = state_vec_t'(1 << S_WAIT_DONE);

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - 8-bit synchronous FIFO with flush and registered read data
module uart_sync_fifo #(
  parameter int DEPTH    = 16,
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                rd_en,
  input  logic                flush,
  output logic [7:0]          rd_data,
  output logic [CNT_BITS-1:0] count,
  output logic                full,
  output logic                empty
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [7:0]          mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                rd_ok;
  logic                wr_ok;

  assign full  = (count == CNT_BITS'(DEPTH));
  assign empty = (count == '0);
  assign rd_ok = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle
  assign wr_ok = wr_en && !flush && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= 8'h00;
    end else begin
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_ok) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({wr_ok, rd_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx_byte_feeder.sv
// rtl/uart_tx_byte_feeder.sv - buffers host bytes and hands them one at a time to the UART TX engine
module uart_tx_byte_feeder
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_BITS   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                flush,
  input  logic                clr_overflow,
  output logic [CNT_BITS-1:0] fifo_count,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                overflow,
  output logic                busy,
  output logic                start_TX,
  output logic [7:0]          SBUF_out,
  input  logic                tx_active
);

  state_vec_t state;
  state_vec_t state_next;
  logic       pop;
  logic       wr_drop;

  uart_sync_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .CNT_BITS (CNT_BITS)
  ) u_fifo (
    .clk        (clk),
    .sync_reset (sync_reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (pop),
    .flush      (flush),
    .rd_data    (SBUF_out),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // A flushed write is discarded on purpose and does not count as an overflow
  assign wr_drop  = wr_en && !flush && fifo_full && !pop;
  assign start_TX = state[S_START];
  assign busy     = !state[S_IDLE] || !fifo_empty;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (1'b1)
      state[S_IDLE]: begin
        if (!fifo_empty && !tx_active) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      state[S_START]:     state_next = ST_WAIT_BUSY;
      // Engine missed the pulse: re-pulse the same byte without popping again
      state[S_WAIT_BUSY]: state_next = tx_active ? ST_WAIT_DONE : ST_START;
      state[S_WAIT_DONE]: if (!tx_active) state_next = ST_IDLE;
      default:            state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state    <= ST_IDLE;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (wr_drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_byte_feeder.sv
// tb/tb_uart_tx_byte_feeder.sv - directed bench for the UART TX byte feeder with a TX engine model
module tb_uart_tx_byte_feeder;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_overflow;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic       busy;
  logic       start_TX;
  logic [7:0] SBUF_out;
  logic       tx_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_byte_feeder #(.FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .overflow     (overflow),
    .busy         (busy),
    .start_TX     (start_TX),
    .SBUF_out     (SBUF_out),
    .tx_active    (tx_active)
  );

  // TX engine model: 10-bit frame, 4 clocks per bit (baud_rate_period_m1 = 3)
  logic       tx_manual;
  logic       tx_force;
  int         ignore_budget;
  int         m_ignored;
  logic       m_active;
  logic [9:0] m_shreg;
  int         m_div;
  int         m_bits;
  logic       txd;

  assign tx_active = tx_manual ? tx_force : m_active;
  assign txd       = m_active ? m_shreg[0] : 1'b1;

  always @(posedge clk) begin
    if (sync_reset) begin
      m_active  <= 1'b0;
      m_shreg   <= '1;
      m_div     <= 0;
      m_bits    <= 0;
      m_ignored <= 0;
    end else if (!m_active) begin
      if (start_TX && !tx_manual) begin
        if (m_ignored < ignore_budget) begin
          m_ignored <= m_ignored + 1;
        end else begin
          m_active <= 1'b1;
          m_shreg  <= {1'b1, SBUF_out, 1'b0};
          m_div    <= 0;
          m_bits   <= 0;
        end
      end
    end else if (m_div == 3) begin
      m_div   <= 0;
      m_shreg <= {1'b1, m_shreg[9:1]};
      if (m_bits == 9) begin
        m_active <= 1'b0;
        m_bits   <= 0;
      end else begin
        m_bits <= m_bits + 1;
      end
    end else begin
      m_div <= m_div + 1;
    end
  end

  logic [7:0] emitted [$];
  int         pulse_cnt = 0;
  logic       log_en;
  logic       txd_log [$];

  always @(posedge clk) begin
    if (!sync_reset && start_TX) begin
      emitted.push_back(SBUF_out);
      pulse_cnt = pulse_cnt + 1;
    end
    if (log_en) txd_log.push_back(txd);
  end

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sync_reset   = 1'b1;
    wr_en        = 1'b0;
    flush        = 1'b0;
    clr_overflow = 1'b0;
    tick();
    @(negedge clk);
    sync_reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || tx_active) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, 32'(n < 3000), 1);
  endtask

  task automatic wait_active(input string name);
    int n = 0;
    while (!tx_active && n < 200) begin
      tick();
      n++;
    end
    check({name, "_active_timeout"}, 32'(n < 200), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_empty"}, fifo_empty, 1);
    check({tag, "_full"}, fifo_full, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_start"}, start_TX, 0);
    check({tag, "_sbuf"}, SBUF_out, 8'h00);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int i;
    int j;
    int gap;
    logic [7:0] b;
    logic [7:0] exp_bytes [2];

    sync_reset    = 1'b1;
    wr_en         = 1'b0;
    wr_data       = 8'h00;
    flush         = 1'b0;
    clr_overflow  = 1'b0;
    tx_manual     = 1'b0;
    tx_force      = 1'b0;
    ignore_budget = 0;
    log_en        = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state and single-byte latency
    do_reset();
    check_reset_outputs("reset");
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    check("lat_count_after_write", fifo_count, 1);
    check("lat_no_early_start", start_TX, 0);
    @(negedge clk);
    wr_en = 1'b0;
    tick();
    check("lat_start_pulse", start_TX, 1);
    check("lat_sbuf", SBUF_out, 8'h55);
    check("lat_count_after_pop", fifo_count, 0);
    tick();
    check("lat_start_one_cycle", start_TX, 0);
    check("lat_tx_active", tx_active, 1);
    wait_idle("lat");

    // Fill to full with the engine held busy, overflow set/clear behaviour
    for (int k = 0; k < 16; k++) begin
      vecs[k] = '{1'b1, 8'(k), 1'b0, 5'(k + 1), (k == 15), 1'b0, 1'b0};
    end
    vecs[16] = '{1'b1, 8'h10, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 8'h11, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};

    tx_manual = 1'b1;
    tx_force  = 1'b1;
    do_reset();
    base = pulse_cnt;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wr_en        = vecs[k].wr;
      wr_data      = vecs[k].data;
      clr_overflow = vecs[k].clr;
      tick();
      check($sformatf("vec%0d_count", k), fifo_count, vecs[k].cnt);
      check($sformatf("vec%0d_full", k), fifo_full, vecs[k].full);
      check($sformatf("vec%0d_empty", k), fifo_empty, vecs[k].empty);
      check($sformatf("vec%0d_ovf", k), overflow, vecs[k].ovf);
    end

    // Full FIFO: write and pop in the same cycle
    @(negedge clk);
    clr_overflow = 1'b0;
    tx_manual    = 1'b0;
    wr_en        = 1'b1;
    wr_data      = 8'hEE;
    tick();
    check("fullpop_count", fifo_count, 16);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_sbuf", SBUF_out, 8'h00);
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle("drain");
    check("drain_pulses", pulse_cnt - base, 17);
    for (int k = 0; k < 17; k++) begin
      if (base + k < emitted.size()) begin
        check($sformatf("drain_byte%0d", k), emitted[base + k], (k < 16) ? 8'(k) : 8'hEE);
      end
    end

    // Engine misses the first start pulse
    ignore_budget = 1;
    do_reset();
    base = pulse_cnt;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hC3;
    tick();
    @(negedge clk);
    wr_data = 8'h3C;
    tick();
    check("ign_first_start", start_TX, 1);
    check("ign_first_count", fifo_count, 1);
    @(negedge clk);
    wr_en = 1'b0;
    tick();
    check("ign_gap_start", start_TX, 0);
    tick();
    check("ign_repulse", start_TX, 1);
    check("ign_repulse_sbuf", SBUF_out, 8'hC3);
    check("ign_repulse_count", fifo_count, 1);
    wait_idle("ign");
    check("ign_pulses", pulse_cnt - base, 3);
    if (base + 2 < emitted.size()) begin
      check("ign_byte0", emitted[base], 8'hC3);
      check("ign_byte1", emitted[base + 1], 8'hC3);
      check("ign_byte2", emitted[base + 2], 8'h3C);
    end
    ignore_budget = 0;

    // Flush during the first frame
    do_reset();
    base = pulse_cnt;
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h11;
    tick();
    @(negedge clk);
    wr_data = 8'h22;
    tick();
    @(negedge clk);
    wr_data = 8'h33;
    tick();
    @(negedge clk);
    wr_data = 8'h44;
    tick();
    check("flush_pre_count", fifo_count, 3);
    @(negedge clk);
    wr_en = 1'b0;
    wait_active("flush");
    @(negedge clk);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    tick();
    check("flush_count", fifo_count, 0);
    check("flush_empty", fifo_empty, 1);
    check("flush_busy_inflight", busy, 1);
    check("flush_tx_active", tx_active, 1);
    @(negedge clk);
    flush = 1'b0;
    wr_en = 1'b0;
    wait_idle("flush");
    repeat (60) tick();
    check("flush_pulses", pulse_cnt - base, 1);
    if (base < emitted.size()) check("flush_byte", emitted[base], 8'h11);

    // Reset in the middle of a frame
    write_byte(8'h99);
    write_byte(8'h77);
    wait_active("midrst");
    repeat (5) tick();
    @(negedge clk);
    sync_reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    check("midrst_tx_active", tx_active, 0);
    @(negedge clk);
    sync_reset = 1'b0;
    repeat (4) tick();
    check("midrst_no_start", start_TX, 0);
    check("midrst_still_idle", busy, 0);

    // Serial line framing for two back-to-back bytes
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'h3C;
    @(negedge clk);
    log_en = 1'b1;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = exp_bytes[0];
    @(negedge clk);
    wr_data = exp_bytes[1];
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle("txd");
    repeat (4) tick();
    @(negedge clk);
    log_en = 1'b0;
    n = txd_log.size();
    i = 0;
    for (int f = 0; f < 2; f++) begin
      while (i < n && txd_log[i] == 1'b1) i++;
      check($sformatf("txd_frame%0d_found", f), 32'(i + 40 <= n), 1);
      if (i + 40 <= n) begin
        check($sformatf("txd_frame%0d_start", f), txd_log[i + 2], 0);
        for (int k = 0; k < 8; k++) b[k] = txd_log[i + 6 + 4 * k];
        check($sformatf("txd_frame%0d_data", f), b, exp_bytes[f]);
        check($sformatf("txd_frame%0d_stop", f), txd_log[i + 38], 1);
        j = i + 40;
        while (j < n && txd_log[j] == 1'b1) j++;
        gap = j - (i + 40);
        if (f == 0) check("txd_gap_ge2", 32'(gap >= 2), 1);
        i = j;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
